mem_arb: RTL
============

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: number of clock cycles the read_n/write_n strobe is held low per access; values below 1 are treated as 1.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1, input, 1 bit each: access request from requester 0/1.
REQ-005 SHALL have ports we0/we1, input, 1 bit each: 1 = write, 0 = read, for requester 0/1.
REQ-006 SHALL have ports addr0/addr1, input, 7 bits each: word address from requester 0/1.
REQ-007 SHALL have ports wdata0/wdata1, input, 8 bits each: write data from requester 0/1.
REQ-008 SHALL have ports done0/done1, output, 1 bit each: one-cycle completion pulse to requester 0/1.
REQ-009 SHALL have port rdata, output, 8 bits: read result, valid while done0 or done1 is high.
REQ-010 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 SHALL have ports ce_n, read_n, write_n, output, 1 bit each, all active-low: memory-interface cycle strobes.
REQ-012 SHALL have port address_bus, output, 7 bits: memory word address.
REQ-013 SHALL have port bus_dout, output, 8 bits: write data driven toward the memory interface.
REQ-014 SHALL have port bus_oe, output, 1 bit: enable for bus_dout onto the shared data bus.
REQ-015 SHALL have port bus_din, input, 8 bits: read data returned from the memory interface.

Function
REQ-016 SHALL implement four states: IDLE, SETUP, ACCESS, HOLD; all outputs SHALL be registered.
REQ-017 In IDLE, ce_n=read_n=write_n=1, bus_oe=0, and req0/req1 SHALL be sampled on each edge.
REQ-018 When exactly one req is high in IDLE, that requester SHALL be granted and the FSM SHALL move to SETUP.
REQ-019 When both reqs are high in IDLE, the grant SHALL go to the requester not served last (round-robin); after reset, requester 0 has priority.
REQ-020 On grant, the granted requester's addr, we and wdata SHALL be latched; later changes to those inputs SHALL have no effect on the current transaction.
REQ-021 SETUP SHALL last 1 cycle: ce_n=0, address_bus=latched address, read_n=write_n=1, and bus_oe=1 for writes only.
REQ-022 ACCESS SHALL last exactly WAIT_CYCLES cycles, counted by an internal down-counter: ce_n=0, plus read_n=0 for a read or write_n=0 for a write.
REQ-023 On a read, bus_din SHALL be captured into rdata on the final ACCESS edge.
REQ-024 HOLD SHALL last 1 cycle: read_n=write_n=1 while ce_n, address_bus, bus_oe and bus_dout are held; done of the granted port =1; then the FSM returns to IDLE.
REQ-025 Total transaction length from the first SETUP cycle through HOLD SHALL be WAIT_CYCLES+2 cycles; every transaction SHALL be followed by at least 1 IDLE cycle.
REQ-026 read_n and write_n SHALL never be low in the same cycle, and neither SHALL be low while ce_n=1.
REQ-027 bus_oe SHALL never be 1 on a read transaction or in IDLE.
REQ-028 Deassertion of req mid-transaction SHALL be ignored; the transaction completes and the done pulse is still issued.
REQ-029 Requester handshake: req is held high until done is seen, then dropped in the same cycle; a req still high in the IDLE cycle after HOLD starts a new transaction.
REQ-030 rdata SHALL retain its last captured value between reads; write transactions SHALL leave rdata unchanged.

Reset
REQ-031 Asserting reset_n=0 at any time, including mid-transaction, SHALL immediately force: state=IDLE, ce_n=read_n=write_n=1, bus_oe=0, done0=done1=0, busy=0, address_bus=0, bus_dout=0, rdata=0, round-robin priority to requester 0.
REQ-032 After reset_n deasserts, the first grant SHALL occur no earlier than the first rising edge at which reset_n=1.

Verification
REQ-033 Read, WAIT_CYCLES=2: req0=1, we0=0, addr0=7'h15, bus_din=8'hA5 -> SETUP 1 cycle; read_n low 2 cycles; done0 pulses with rdata=8'hA5; address_bus=7'h15 throughout; bus_oe=0 throughout.
REQ-034 Write: req1=1, we1=1, addr1=7'h7F, wdata1=8'h3C -> bus_oe=1 and bus_dout=8'h3C from SETUP through HOLD; write_n low 2 cycles; done1 pulse; rdata unchanged.
REQ-035 Contention: req0 and req1 high together, held continuously -> grant order 0,1,0,1 with one IDLE cycle between transactions; done0/done1 alternate.
REQ-036 Reset during ACCESS of a write -> strobes high and bus_oe=0 in the same cycle as reset_n falls; no done pulse; after release, simultaneous requests grant requester 0 first.
REQ-037 WAIT_CYCLES=0 build: any read -> read_n low exactly 1 cycle; transaction length 3 cycles.
REQ-038 Assertion checks in all scenarios: no cycle with read_n=write_n=0; no strobe low while ce_n=1; no bus_oe=1 on reads.

Source files
------------

// File: rtl/mem_arb.sv
// Two-port round-robin arbiter driving an asynchronous-SRAM-style strobe interface.
// Each access runs SETUP, ACCESS (WAIT_CYCLES long) and HOLD, then returns to IDLE.
module mem_arb #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       ce_n,
    output logic       read_n,
    output logic       write_n,
    output logic [6:0] address_bus,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din
);

    localparam int unsigned WaitEff = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int unsigned CntW    = (WaitEff > 1) ? $clog2(WaitEff) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(WaitEff - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic [6:0]        addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              ce_n_q, ce_n_d;
    logic              read_n_q, read_n_d;
    logic              write_n_q, write_n_d;
    logic              oe_q, oe_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              busy_q, busy_d;
    logic              gnt_pick;

    // last_q = 1 means requester 1 was served last, so requester 0 wins a tie.
    assign gnt_pick = (req0 && req1) ? ~last_q : req1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            gnt_q     <= 1'b0;
            we_q      <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            dout_q    <= '0;
            rdata_q   <= '0;
            ce_n_q    <= 1'b1;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
            oe_q      <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rdata_q   <= rdata_d;
            ce_n_q    <= ce_n_d;
            read_n_q  <= read_n_d;
            write_n_q <= write_n_d;
            oe_q      <= oe_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and transaction latching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        last_d  = last_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StSetup;
                    gnt_d   = gnt_pick;
                    last_d  = gnt_pick;
                    we_d    = gnt_pick ? we1 : we0;
                    addr_d  = gnt_pick ? addr1 : addr0;
                    dout_d  = gnt_pick ? wdata1 : wdata0;
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = CntLoad;
            end
            StAccess: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    if (!we_q) begin
                        rdata_d = bus_din;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers track state_q exactly.
    always_comb begin
        ce_n_d    = 1'b1;
        read_n_d  = 1'b1;
        write_n_d = 1'b1;
        oe_d      = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        busy_d    = (state_d != StIdle);
        case (state_d)
            StSetup: begin
                ce_n_d = 1'b0;
                oe_d   = we_d;
            end
            StAccess: begin
                ce_n_d    = 1'b0;
                read_n_d  = we_d;
                write_n_d = ~we_d;
                oe_d      = we_d;
            end
            StHold: begin
                ce_n_d  = 1'b0;
                oe_d    = we_d;
                done0_d = ~gnt_d;
                done1_d = gnt_d;
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
    end

    assign done0       = done0_q;
    assign done1       = done1_q;
    assign rdata       = rdata_q;
    assign busy        = busy_q;
    assign ce_n        = ce_n_q;
    assign read_n      = read_n_q;
    assign write_n     = write_n_q;
    assign address_bus = addr_q;
    assign bus_dout    = dout_q;
    assign bus_oe      = oe_q;

endmodule
